// File: rtl/pll_rst_seq_pkg.sv
// Shared types and parameter defaults for the PLL power-up / reset sequencer.
// The FAULT state only exists when PLL_RST_SEQ_LOCKLOSS_EN is defined.
package pll_rst_seq_pkg;

    localparam int DEF_NUM_DOM     = 3;
    localparam int DEF_PD_CYCLES   = 8;
    localparam int DEF_LOCK_STABLE = 1024;
    localparam int DEF_STAGGER     = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        PWRDN,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
        , FAULT
`endif
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL lock into the clk_i domain.
module pll_rst_seq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_q[gi] <= d_i;
                end else begin
                    sync_q[gi] <= sync_q[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL power-down / lock-qualification / staggered domain reset release sequencer.
// Define PLL_RST_SEQ_LOCKLOSS_EN to restart the whole sequence when lock is lost in RUN.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int PD_CYCLES   = DEF_PD_CYCLES,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pll_lock_i,
    output logic               pll_pwrdn_n_o,
    output logic [NUM_DOM-1:0] rst_dom_o,
    output logic               seq_done_o,
    output logic               lock_lost_o
);

    localparam int CNT_MAX = max3(PD_CYCLES, LOCK_STABLE, STAGGER);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               pwrdn_n_q, pwrdn_n_d;
    logic [NUM_DOM-1:0] rst_dom_q, rst_dom_d, rst_dom_shl;
    logic               done_q, done_d;
    logic               lock_s;
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
    logic               lost_q, lost_d;
`endif

    pll_rst_seq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (pll_lock_i),
        .q_o  (lock_s)
    );

    assign cnt_inc     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    // Domains release LSB first: shifting zeros in from bit 0 clears the next one.
    assign rst_dom_shl = rst_dom_q << 1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pwrdn_n_d = pwrdn_n_q;
        rst_dom_d = rst_dom_q;
        done_d    = done_q;
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
        lost_d    = 1'b0;
`endif
        case (state_q)
            PWRDN: begin
                if (cnt_q >= CNT_W'(PD_CYCLES - 1)) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pwrdn_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(LOCK_STABLE)) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    rst_dom_d = rst_dom_shl;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    rst_dom_d = '1;
                end else if (NUM_DOM == 1) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else if (cnt_q >= CNT_W'(STAGGER - 1)) begin
                    cnt_d     = '0;
                    rst_dom_d = rst_dom_shl;
                    if (rst_dom_shl == '0) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                done_d = 1'b1;
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
                if (!lock_s) begin
                    state_d   = FAULT;
                    cnt_d     = '0;
                    rst_dom_d = '1;
                    done_d    = 1'b0;
                    lost_d    = 1'b1;
                end
`endif
            end
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
            FAULT: begin
                state_d   = PWRDN;
                cnt_d     = '0;
                pwrdn_n_d = 1'b0;
            end
`endif
            default: begin
                state_d   = PWRDN;
                cnt_d     = '0;
                pwrdn_n_d = 1'b0;
                rst_dom_d = '1;
                done_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= PWRDN;
            cnt_q     <= '0;
            pwrdn_n_q <= 1'b0;
            rst_dom_q <= '1;
            done_q    <= 1'b0;
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
            lost_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pwrdn_n_q <= pwrdn_n_d;
            rst_dom_q <= rst_dom_d;
            done_q    <= done_d;
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
            lost_q    <= lost_d;
`endif
        end
    end

    assign pll_pwrdn_n_o = pwrdn_n_q;
    assign rst_dom_o     = rst_dom_q;
    assign seq_done_o    = done_q;
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
    assign lock_lost_o   = lost_q;
`else
    assign lock_lost_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq (NUM_DOM=3, PD=4, LOCK_STABLE=8, STAGGER=4, SYNC=2).
// Lock loss in RUN is checked against whichever build PLL_RST_SEQ_LOCKLOSS_EN selects.
module tb_pll_rst_seq;

    logic       clk;
    logic       rst_i;
    logic       pll_lock_i;
    logic       pll_pwrdn_n_o;
    logic [2:0] rst_dom_o;
    logic       seq_done_o;
    logic       lock_lost_o;

    // Snapshot bit positions: {pwrdn_n, rst_dom[2:0], done, lost}
    localparam int B_LOST = 0;
    localparam int B_DONE = 1;
    localparam int B_D0   = 2;
    localparam int B_D1   = 3;
    localparam int B_PWR  = 5;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lost_seen = 0;
    int   n;
    int   lost_base;

    pll_rst_seq #(
        .NUM_DOM    (3),
        .PD_CYCLES  (4),
        .LOCK_STABLE(8),
        .STAGGER    (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pll_lock_i   (pll_lock_i),
        .pll_pwrdn_n_o(pll_pwrdn_n_o),
        .rst_dom_o    (rst_dom_o),
        .seq_done_o   (seq_done_o),
        .lock_lost_o  (lock_lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lock_lost_o === 1'b1) lost_seen++;
    end

    function automatic int obs();
        return int'({pll_pwrdn_n_o, rst_dom_o, seq_done_o, lock_lost_o});
    endfunction

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_obs(input int got);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (got === e.val)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, got, e.val);
        end
    endtask

    // Cycles until snapshot bit b reaches lvl; an expired bound returns the bound.
    task automatic wait_bit(input int b, input logic lvl, input int bound, output int cnt);
        int o;
        cnt = 0;
        o = obs();
        while (o[b] !== lvl && cnt < bound) begin
            tick(1);
            cnt++;
            o = obs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        pll_lock_i = 1'b1;

        // Power-up with lock stable throughout
        tick(3);
        expect_val("reset_state", 6'b0_111_00);
        check_obs(obs());
        rst_i = 1'b0;
        expect_val("pwrdn_len", 4);
        wait_bit(B_PWR, 1'b1, 50, n);
        check_obs(n);
        // one WAIT_LOCK cycle, eight counted STABLE cycles, one to see the count reached
        expect_val("dom0_fall", 10);
        wait_bit(B_D0, 1'b0, 100, n);
        check_obs(n);
        expect_val("dom0_state", 6'b1_110_00);
        check_obs(obs());
        expect_val("dom1_fall", 4);
        wait_bit(B_D1, 1'b0, 50, n);
        check_obs(n);
        expect_val("dom2_fall", 4);
        wait_bit(B_DONE, 1'b1, 50, n);
        check_obs(n);
        expect_val("run_state", 6'b1_000_10);
        check_obs(obs());

        // Lock loss while running
        lost_base = lost_seen;
        pll_lock_i = 1'b0;
`ifdef PLL_RST_SEQ_LOCKLOSS_EN
        expect_val("lost_latency", 3);
        wait_bit(B_LOST, 1'b1, 20, n);
        check_obs(n);
        expect_val("fault_state", 6'b1_111_01);
        check_obs(obs());
        tick(1);
        expect_val("fault_pwrdn", 6'b0_111_00);
        check_obs(obs());
        pll_lock_i = 1'b1;
        expect_val("re_pwrdn_len", 4);
        wait_bit(B_PWR, 1'b1, 50, n);
        check_obs(n);
        expect_val("re_dom0_fall", 10);
        wait_bit(B_D0, 1'b0, 100, n);
        check_obs(n);
        expect_val("re_done", 8);
        wait_bit(B_DONE, 1'b1, 50, n);
        check_obs(n);
        expect_val("re_run_state", 6'b1_000_10);
        check_obs(obs());
        expect_val("lost_pulses", 1);
        check_obs(lost_seen - lost_base);
`else
        tick(8);
        expect_val("run_hold", 6'b1_000_10);
        check_obs(obs());
        expect_val("no_lost_pulse", 0);
        check_obs(lost_seen - lost_base);
        pll_lock_i = 1'b1;
`endif

        // Lock glitch during STABLE restarts qualification
        rst_i      = 1'b1;
        pll_lock_i = 1'b0;
        tick(2);
        rst_i = 1'b0;
        expect_val("glitch_pwrdn_len", 4);
        wait_bit(B_PWR, 1'b1, 50, n);
        check_obs(n);
        lost_base  = lost_seen;
        pll_lock_i = 1'b1;
        tick(5);
        pll_lock_i = 1'b0;
        tick(1);
        pll_lock_i = 1'b1;
        // two sync flops, WAIT_LOCK, eight STABLE counts, detection cycle
        expect_val("relock_dom0_fall", 12);
        wait_bit(B_D0, 1'b0, 100, n);
        check_obs(n);

        // Lock drop between dom0 and dom1 releases
        pll_lock_i = 1'b0;
        expect_val("release_abort", 3);
        wait_bit(B_D0, 1'b1, 20, n);
        check_obs(n);
        expect_val("abort_state", 6'b1_111_00);
        check_obs(obs());
        pll_lock_i = 1'b1;
        expect_val("resume_dom0_fall", 12);
        wait_bit(B_D0, 1'b0, 100, n);
        check_obs(n);
        expect_val("resume_dom1_fall", 4);
        wait_bit(B_D1, 1'b0, 50, n);
        check_obs(n);
        expect_val("partial_state", 6'b1_100_00);
        check_obs(obs());
        expect_val("no_lost_in_release", 0);
        check_obs(lost_seen - lost_base);

        // Reset in the middle of RELEASE
        rst_i = 1'b1;
        tick(1);
        expect_val("rst_in_release", 6'b0_111_00);
        check_obs(obs());
        tick(1);
        expect_val("rst_hold", 6'b0_111_00);
        check_obs(obs());
        rst_i = 1'b0;
        tick(1);
        expect_val("post_rst_pwrdn", 6'b0_111_00);
        check_obs(obs());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
